// File: rtl/game_pkg.sv
// Shared game-flow types: phase codes and switch-decode helpers.
// Latency: none, types and pure combinational functions only.
// Backpressure: not applicable.
package game_pkg;

   // Widest switch bank any client block may decode
   localparam int MAX_POWERS = 16;
   localparam int IDX_W      = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READY   = 3'd1,
      ST_SELECT  = 3'd2,
      ST_ALL_SET = 3'd3
   } game_state_t;

   // True when exactly one switch is set
   function automatic logic onehot_valid(input logic [MAX_POWERS-1:0] v);
      int cnt;
      cnt = 0;
      for (int i = 0; i < MAX_POWERS; i++) cnt += int'(v[i]);
      return (cnt == 1);
   endfunction

   // Binary position of the set bit; only meaningful when onehot_valid is true
   function automatic logic [IDX_W-1:0] onehot_to_index(input logic [MAX_POWERS-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_POWERS; i++) if (v[i]) idx = IDX_W'(i);
      return idx;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Countdown tick generator: one-cycle pulse every CLK_HZ/TICK_HZ cycles.
// Latency: first tick DIV cycles after reset or clear.
// Backpressure: none; clear restarts the period immediately.
module tick_gen #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Free-running divider; clear restarts a full period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     cnt <= '0;
      else if (clear || cnt == LAST)  cnt <= '0;
      else                            cnt <= cnt + CW'(1);
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/game_flow_ctrl.sv
// Pre-game flow controller: idle/ready/per-player power select/all-set with countdown and auto-assign.
// Latency: 4 cycles from a raw start/confirm edge to state/locked change; reject is a registered 1-cycle pulse.
// Backpressure: none; events not meaningful in the current phase are dropped.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int NUM_POWERS  = 9,
   parameter int CLK_HZ      = 50_000_000,
   parameter int TICK_HZ     = 4,
   parameter int SEL_TICKS   = 40,
   localparam int PW  = $clog2(NUM_POWERS),
   localparam int PLW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_POWERS-1:0]     SW,
   input  logic                      start,
   input  logic                      confirm,
   output logic [2:0]                state,
   output logic [PLW-1:0]            cur_player,
   output logic [7:0]                countdown,
   output logic [NUM_PLAYERS*PW-1:0] powers,
   output logic [NUM_PLAYERS-1:0]    locked,
   output logic                      reject,
   output logic                      LEDR
);

   localparam logic [7:0]     SEL_LOAD = 8'(SEL_TICKS);
   localparam logic [PLW-1:0] LAST_PL  = PLW'(NUM_PLAYERS - 1);

   logic [NUM_POWERS-1:0] sw_s1, sw_s2;
   logic start_s1, start_s2, start_q, start_evt;
   logic confirm_s1, confirm_s2, confirm_q, confirm_evt;

   game_state_t               state_q, state_d;
   logic [PLW-1:0]            cp_q, cp_d;
   logic [7:0]                cd_q, cd_d;
   logic [NUM_PLAYERS*PW-1:0] powers_q, powers_d;
   logic [NUM_PLAYERS-1:0]    locked_q, locked_d;
   logic                      reject_q, reject_d;
   logic                      blink_q, blink_d;

   logic          tick, restart, do_lock, sel_valid, sel_taken, used;
   logic [PW-1:0] sel_idx, free_idx, lock_idx;

   // Two-flop synchronisers plus registered rising-edge detection of the buttons
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1 <= '0; sw_s2 <= '0;
         start_s1 <= 1'b0; start_s2 <= 1'b0; start_q <= 1'b0; start_evt <= 1'b0;
         confirm_s1 <= 1'b0; confirm_s2 <= 1'b0; confirm_q <= 1'b0; confirm_evt <= 1'b0;
      end else begin
         sw_s1       <= SW;
         sw_s2       <= sw_s1;
         start_s1    <= start;
         start_s2    <= start_s1;
         start_q     <= start_s2;
         start_evt   <= start_s2 & ~start_q;
         confirm_s1  <= confirm;
         confirm_s2  <= confirm_s1;
         confirm_q   <= confirm_s2;
         confirm_evt <= confirm_s2 & ~confirm_q;
      end
   end

   assign sel_valid = onehot_valid(MAX_POWERS'(sw_s2));
   assign sel_idx   = PW'(onehot_to_index(MAX_POWERS'(sw_s2)));

   tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (restart),
      .tick  (tick)
   );

   // Check the selection against held powers and find the lowest free power
   always_comb begin
      sel_taken = 1'b0;
      free_idx  = '0;
      used      = 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++)
         if (locked_q[p] && powers_q[p*PW +: PW] == sel_idx) sel_taken = 1'b1;
      for (int k = NUM_POWERS - 1; k >= 0; k--) begin
         used = 1'b0;
         for (int p = 0; p < NUM_PLAYERS; p++)
            if (locked_q[p] && powers_q[p*PW +: PW] == PW'(k)) used = 1'b1;
         if (!used) free_idx = PW'(k);
      end
   end

   // Phase sequencing: confirm/timeout locking, advance and countdown
   always_comb begin
      state_d  = state_q;
      cp_d     = cp_q;
      cd_d     = cd_q;
      powers_d = powers_q;
      locked_d = locked_q;
      reject_d = 1'b0;
      blink_d  = blink_q;
      restart  = 1'b0;
      do_lock  = 1'b0;
      lock_idx = free_idx;
      case (state_q)
         ST_IDLE: if (start_evt) state_d = ST_READY;
         ST_READY: if (start_evt) begin
            state_d = ST_SELECT;
            cp_d    = '0;
            cd_d    = SEL_LOAD;
            blink_d = 1'b0;
            restart = 1'b1;
         end
         ST_SELECT: begin
            if (confirm_evt) begin
               if (sel_valid && !sel_taken) begin
                  do_lock  = 1'b1;
                  lock_idx = sel_idx;
               end else begin
                  reject_d = 1'b1;
               end
            end
            // A valid confirm takes precedence over the final tick
            if (!do_lock && tick) begin
               if (cd_q == 8'd1) begin
                  do_lock  = 1'b1;
                  lock_idx = free_idx;
               end else begin
                  cd_d = cd_q - 8'd1;
                  if (cd_q <= 8'd8) blink_d = ~blink_q;
               end
            end
            if (do_lock) begin
               powers_d[int'(cp_q)*PW +: PW] = lock_idx;
               locked_d[cp_q] = 1'b1;
               blink_d = 1'b0;
               restart = 1'b1;
               if (cp_q == LAST_PL) begin
                  state_d = ST_ALL_SET;
                  cp_d    = '0;
                  cd_d    = '0;
               end else begin
                  cp_d = cp_q + PLW'(1);
                  cd_d = SEL_LOAD;
               end
            end
         end
         ST_ALL_SET: if (start_evt) begin
            state_d  = ST_IDLE;
            powers_d = '0;
            locked_d = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Phase and selection state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cp_q     <= '0;
         cd_q     <= '0;
         powers_q <= '0;
         locked_q <= '0;
         reject_q <= 1'b0;
         blink_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cp_q     <= cp_d;
         cd_q     <= cd_d;
         powers_q <= powers_d;
         locked_q <= locked_d;
         reject_q <= reject_d;
         blink_q  <= blink_d;
      end
   end

   assign state      = state_q;
   assign cur_player = cp_q;
   assign countdown  = cd_q;
   assign powers     = powers_q;
   assign locked     = locked_q;
   assign reject     = reject_q;
   assign LEDR       = (state_q == ST_ALL_SET) | ((state_q == ST_SELECT) & blink_q);

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised game-flow controller for the FPGA game top level: it sequences the pre-game phases (idle, ready, per-player power selection, all-set) for `NUM_PLAYERS` players choosing from `NUM_POWERS` switch-selected powers. It adds behaviour the current state manager lacks: a per-player selection countdown, rejection of powers already taken, and auto-assignment on timeout. It drives the LCD text state code, HEX power/countdown digits and status LED.

## Interface
- `NUM_PLAYERS`, 2: players selecting in turn, 1..8.
- `NUM_POWERS`, 9: selectable powers, one switch each, 2..16.
- `CLK_HZ`, 50_000_000: `clk` frequency.
- `TICK_HZ`, 4: countdown tick rate; `CLK_HZ` must be divisible by it.
- `SEL_TICKS`, 40: countdown ticks per player (10 s at 4 Hz), 1..255.
- Derived: `PW = $clog2(NUM_POWERS)`, `PLW = max(1, $clog2(NUM_PLAYERS))`.
- `clk` in 1: system clock, `CLK_HZ`.
- `rst_n` in 1: asynchronous active-low reset.
- `SW` in `NUM_POWERS`: raw power switches, asynchronous.
- `start` in 1: debounced start button, active-high, asynchronous.
- `confirm` in 1: debounced confirm button, active-high, asynchronous.
- `state` out 3: phase code. IDLE=0, READY=1, SELECT=2, ALL_SET=3.
- `cur_player` out `PLW`: player currently selecting. 0 outside SELECT.
- `countdown` out 8: remaining ticks for the current player. 0 outside SELECT.
- `powers` out `NUM_PLAYERS*PW`: locked power of player i at `[i*PW +: PW]`.
- `locked` out `NUM_PLAYERS`: bit i set once player i is locked.
- `reject` out 1: one-cycle pulse when a confirm is refused.
- `LEDR` out 1: high in ALL_SET; toggles every tick in SELECT when `countdown` ≤ 8.

## Operation
- All inputs pass through 2-FF synchronisers. `start` and `confirm` are rising-edge detected after synchronisation, so each produces a one-cycle event.
- Selection is valid when synchronised `SW` is exactly one-hot. The index is the binary position of the set bit.
- IDLE: on a `start` event go to READY.
- READY: on a `start` event go to SELECT with `cur_player`=0 and `countdown`=`SEL_TICKS`.
- SELECT, `confirm` event with a valid selection whose index is not held by any locked player: lock it, set `locked[cur_player]`, then advance.
- SELECT, `confirm` event with an invalid selection (zero or multi-hot) or a taken power: pulse `reject`. `countdown` is not reloaded.
- SELECT, tick with `countdown`=1: auto-lock the lowest-index free power, then advance. No `reject` pulse.
- Advance: if `cur_player`=`NUM_PLAYERS-1`, go to ALL_SET; otherwise increment `cur_player` and reload `countdown`=`SEL_TICKS`.
- ALL_SET: hold all outputs. A `start` event clears `locked`/`powers` and returns to IDLE.
- A confirm event and the final tick in the same cycle: the confirm wins if valid. If it is invalid, the timeout auto-lock happens and `reject` still pulses.
- `NUM_PLAYERS` ≤ `NUM_POWERS` is required. A free power therefore always exists.

## Timing
- Reset values: `state`=IDLE, `cur_player`=0, `countdown`=0, `powers`=0, `locked`=0, `reject`=0, `LEDR`=0, tick divider=0, synchronisers=0.
- Input to internal event latency: 3 cycles (2 sync + edge register). State and outputs update on the following edge. Total: 4 cycles from a raw pin edge to `state`/`locked` change.
- Tick: one-cycle pulse every `CLK_HZ/TICK_HZ` cycles. The divider runs freely and is restarted (cleared) on every entry to SELECT and on every advance, so each player gets exactly `SEL_TICKS` full tick periods.
- `countdown` decrements on each tick while in SELECT. It never wraps below 1 while in SELECT.
- `reject` is registered and high for exactly 1 cycle.
- Asserting reset mid-selection immediately clears all locks. There is no partial state retention.

## Structure
- Package `game_pkg`: the state enum (IDLE/READY/SELECT/ALL_SET, 3-bit) and the `onehot_to_index`/valid helper function. It is shared with the LCD and HEX display blocks.
- Sub-module `tick_gen`: parameters `CLK_HZ`, `TICK_HZ`. Inputs `clk`, `rst_n`, `clear`. Output `tick`. It replaces the ad-hoc divider for this block.
- Taken-power check and lowest-free search are combinational loops over `NUM_PLAYERS`/`NUM_POWERS`.

## Test plan
- Small parameters (`CLK_HZ`=8, `TICK_HZ`=1, `SEL_TICKS`=4).
- Reset mid-SELECT, after P0 has locked power 3 → `state`=0, `locked`=0, `powers`=0 immediately (asynchronous).
- start, start, `SW`=9'b000001000 + confirm, then `SW`=9'b000100000 + confirm → `powers`={5,3}, `locked`=2'b11, `state`=3, `LEDR`=1.
- P0 locks 3; P1 sets `SW`=3'th bit + confirm → `reject` pulses once, `locked`=2'b01, `countdown` unchanged.
- `SW`=9'b000000110 + confirm → `reject`. `SW`=0 + confirm → `reject`.
- P0 locks 0; P1 idles for 4 ticks → P1 auto-locked to power 1 exactly 32 cycles after its SELECT entry, `state`=3, no `reject`.
- Valid confirm in the same cycle as the final tick → the confirmed power is locked, not the auto power.
